// File: rtl/mem_dma_if.sv
// Bundle of request/status and memory-port signals for mem_dma.
// The fill/fill_data pair exists only when MEM_DMA_FILL_EN is defined.
interface mem_dma_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
`ifdef MEM_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_data;
`endif

  // master = the DMA engine, slave = the requester plus memory
  modport master (
    input  start, src, dst, len, mem_dout,
`ifdef MEM_DMA_FILL_EN
    input  fill, fill_data,
`endif
    output busy, done, mem_addr, mem_din, mem_we
  );

  modport slave (
    output start, src, dst, len, mem_dout,
`ifdef MEM_DMA_FILL_EN
    output fill, fill_data,
`endif
    input  busy, done, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/mem_dma.sv
// mem_dma: byte-wise memory copy engine, one READ and one WRITE cycle per byte.
// Define MEM_DMA_FILL_EN to add fill mode (constant pattern, one WRITE cycle per byte).
module mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic      clk,
  input  logic      rst,
  mem_dma_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] offset;
  logic [DW-1:0] hold;
  logic          fill_start;
  logic          fill_mode;
  logic          last;

`ifdef MEM_DMA_FILL_EN
  logic          fill_q;
  logic [DW-1:0] fill_data_q;
  assign fill_start = bus.fill;
  assign fill_mode  = fill_q;
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
`endif

  assign last = ((offset + ONE) == len_q);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0)   state_nxt = DONE;
          else if (fill_start) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      READ: begin
        bus.busy     = 1'b1;
        bus.mem_addr = src_q + offset;
        state_nxt    = WRITE;
      end
      WRITE: begin
        bus.busy     = 1'b1;
        bus.mem_addr = dst_q + offset;
        bus.mem_we   = 1'b1;
`ifdef MEM_DMA_FILL_EN
        bus.mem_din  = fill_q ? fill_data_q : hold;
`else
        bus.mem_din  = hold;
`endif
        if (last)           state_nxt = DONE;
        else if (fill_mode) state_nxt = WRITE;
        else                state_nxt = READ;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Quiet outputs while reset is held so an abort issues no further write.
    if (!rst) begin
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.mem_addr = '0;
      bus.mem_din  = '0;
      bus.mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      offset      <= '0;
      hold        <= '0;
`ifdef MEM_DMA_FILL_EN
      fill_q      <= 1'b0;
      fill_data_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_q       <= bus.src;
            dst_q       <= bus.dst;
            len_q       <= bus.len;
            offset      <= '0;
`ifdef MEM_DMA_FILL_EN
            fill_q      <= bus.fill;
            fill_data_q <= bus.fill_data;
`endif
          end
        end
        READ:    hold   <= bus.mem_dout;
        WRITE:   offset <= offset + ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural memory and a write scoreboard.
module tb_mem_dma;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_dma_if #(.AW(8), .DW(8)) bus ();
  mem_dma #(.AW(8), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic       hw_en   = 1'b0;
  logic [7:0] hw_addr = 8'h00;
  logic [7:0] hw_dat  = 8'h00;
  int         vectors  = 0;
  int         errors   = 0;
  int         we_count = 0;
  wr_t        exp_q[$];

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_din;
    else if (hw_en)  mem[hw_addr]      <= hw_dat;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DUT write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", 32'(bus.mem_din), 32'(e.data));
      end
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    hw_en = 1'b1; hw_addr = a; hw_dat = d;
    model[a] = d;
    @(negedge clk);
    hw_en = 1'b0;
  endtask

  // Byte-by-byte reference copy; pushes expected writes in ascending order.
  task automatic expect_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] sa, da;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      model[da] = model[sa];
      e.addr = da; e.data = model[sa];
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    @(negedge clk);
    bus.src = s; bus.dst = d; bus.len = n; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after accept) in which done rises; 0 on timeout.
  task automatic wait_done(input bit poke, output int c);
    c = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (poke && i == 3) begin
        bus.start = 1'b1; bus.src = 8'h99; bus.dst = 8'hC0; bus.len = 8'h07;
      end
      if (poke && i == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] d);
    check(tag, 32'(mem[a]), 32'(d));
  endtask

  initial begin
    int         c;
    bit         done_seen;
    logic [7:0] pat [4];

    bus.start = 1'b0; bus.src = 8'h00; bus.dst = 8'h00; bus.len = 8'h00;
`ifdef MEM_DMA_FILL_EN
    bus.fill = 1'b0; bus.fill_data = 8'h00;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_we",   32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_din",  32'(bus.mem_din), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Plain copy, with start poked mid-transfer and in the DONE cycle
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    for (int i = 0; i < 4; i++) host_write(8'h10 + 8'(i), pat[i]);
    expect_copy(8'h10, 8'h40, 4);
    we_count = 0;
    launch(8'h10, 8'h40, 8'd4);
    wait_done(1'b1, c);
    check("copy_done_cycle", 32'(c), 32'd9);
    check("copy_busy_in_done", 32'(bus.busy), 32'd1);
    bus.start = 1'b1; bus.src = 8'h10; bus.dst = 8'h90; bus.len = 8'd2;
    @(negedge clk);
    check("copy_idle_busy", 32'(bus.busy), 32'd0);
    check("copy_idle_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_start_ignored", 32'(bus.busy), 32'd0);
    check("copy_we_count", 32'(we_count), 32'd4);
    check("copy_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) check_mem("copy_mem", 8'h40 + 8'(i), pat[i]);

    // Empty transfer
    we_count = 0;
    launch(8'h30, 8'h50, 8'd0);
    wait_done(1'b0, c);
    check("empty_done_cycle", 32'(c), 32'd1);
    check("empty_busy_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("empty_busy_after", 32'(bus.busy), 32'd0);
    check("empty_we_count", 32'(we_count), 32'd0);

    // Address wrap
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) host_write(8'hFE + 8'(i), pat[i]);
    expect_copy(8'hFE, 8'h02, 4);
    launch(8'hFE, 8'h02, 8'd4);
    wait_done(1'b0, c);
    check("wrap_done_cycle", 32'(c), 32'd9);
    for (int i = 0; i < 4; i++) check_mem("wrap_mem", 8'h02 + 8'(i), pat[i]);

    // Overlap src<dst replicates the first byte
    host_write(8'h20, 8'h5A);
    for (int i = 1; i < 4; i++) host_write(8'h20 + 8'(i), 8'h00);
    expect_copy(8'h20, 8'h21, 3);
    launch(8'h20, 8'h21, 8'd3);
    wait_done(1'b0, c);
    check("ovl_done_cycle", 32'(c), 32'd7);
    for (int i = 1; i < 4; i++) check_mem("ovl_mem", 8'h20 + 8'(i), 8'h5A);

    // Abort: reset driven in cycle k+5 of a len=8 copy
    for (int i = 0; i < 8; i++) host_write(8'h60 + 8'(i), 8'h70 + 8'(i));
    for (int i = 0; i < 8; i++) host_write(8'hA0 + 8'(i), 8'h00);
    expect_copy(8'h60, 8'hA0, 2);
    we_count  = 0;
    done_seen = 1'b0;
    launch(8'h60, 8'hA0, 8'd8);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen = 1'b1;
      if (i == 2) bus.start = 1'b1;
      if (i == 3) bus.start = 1'b0;
      if (i == 5) rst = 1'b0;
    end
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_we",   32'(bus.mem_we), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_writes_le2", 32'(we_count <= 2), 32'd1);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    check_mem("abort_byte2_untouched", 8'hA2, 8'h00);

`ifdef MEM_DMA_FILL_EN
    // Fill mode: one write per byte, no reads
    we_count = 0;
    for (int i = 0; i < 3; i++) begin
      wr_t e;
      e.addr = 8'h80 + 8'(i); e.data = 8'hE7;
      model[e.addr] = 8'hE7;
      exp_q.push_back(e);
    end
    bus.fill = 1'b1; bus.fill_data = 8'hE7;
    launch(8'h00, 8'h80, 8'd3);
    bus.fill = 1'b0; bus.fill_data = 8'h00;
    wait_done(1'b0, c);
    check("fill_done_cycle", 32'(c), 32'd4);
    check("fill_we_count", 32'(we_count), 32'd3);
    for (int i = 0; i < 3; i++) check_mem("fill_mem", 8'h80 + 8'(i), 8'hE7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
